mult_share_ctrl: RTL and testbench

//  Shares one 5-bit signed shift-add multiplier among NUM_REQ requesters and sequences it.

---
 rtl/mult_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/mult_share_ctrl.sv | 127 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and sequencing states for the shared signed-multiplier controller.
package mult_pkg;
  localparam int OP_W   = 5;
  localparam int PROD_W = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  // Offset i walks the ring from ptr; inner loop keeps every index a constant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_req && req[j] && ((int'(ptr) + i) % NUM_REQ) == j) begin
          grant[j]  = 1'b1;
          grant_idx = ID_W'(j);
          any_req   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Arbitrates NUM_REQ requesters onto one magnitude-only multiplier and restores the sign.
//
// state | meaning
// IDLE  | waiting for a request; grant, accept pulse and operand latch happen here
// ISSUE | operands on mul_a/mul_b, mul_enable high for this one cycle
// WAIT  | multiplier product valid; signed result and owner id captured
// RESP  | rsp_valid high until the consumer takes the result
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_result,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  output logic                    mul_enable,
  input  logic [PROD_W-1:0]       mul_result,
  output logic [15:0]             ops_done
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                any_req;
  logic [OP_W-1:0]     sel_a, sel_b;
  logic [OP_W-1:0]     op_a, op_b;
  logic                op_sign;
  logic [ID_W-1:0]     op_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = req_a[i*OP_W +: OP_W];
        sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so the accept pulse cannot leak while reset is held.
  always_comb begin
    req_ready  = '0;
    mul_enable = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE:    if (rst) req_ready = grant_oh;
      ISSUE:   mul_enable = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sign    <= 1'b0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      ops_done   <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_sign <= sel_a[OP_W-1] ^ sel_b[OP_W-1];
            op_id   <= grant_idx;
          end
        end
        WAIT: begin
          rsp_result <= op_sign ? (~mul_result + 1'b1) : mul_result;
          rsp_id     <= op_id;
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + 16'd1;
            rr_ptr   <= (int'(op_id) == NUM_REQ - 1) ? '0 : op_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a = op_a;
  assign mul_b = op_b;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural magnitude multiplier attached.
module tb_mult_share_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_result;
  logic [4:0]  mul_a, mul_b;
  logic        mul_enable;
  logic [9:0]  mul_result = '0;
  logic [15:0] ops_done;

  int vectors = 0;
  int miscompares = 0;

  mult_share_ctrl #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_enable (mul_enable),
    .mul_result (mul_result),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] mag(input logic [4:0] v);
    return v[4] ? (6'd32 - {1'b0, v}) : {1'b0, v};
  endfunction

  // External multiplier: |A|*|B| registered on the enable edge.
  always @(posedge clk) begin
    if (mul_enable) mul_result <= 10'(mag(mul_a) * mag(mul_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [4:0] a, input logic [4:0] b);
    req_a[i*5 +: 5] = a;
    req_b[i*5 +: 5] = b;
  endtask

  // Called in IDLE with inputs applied; returns one cycle after the RESP handshake.
  task automatic op(input int g, input logic [4:0] ea, input logic [4:0] eb,
                    input logic [9:0] eres, input int nstall, input logic [3:0] next_valid);
    rsp_ready = (nstall == 0);
    #1;
    chk("grant", 32'(req_ready), 32'(1 << g));
    tick();
    req_valid = next_valid;
    #1;
    chk("issue_en", 32'(mul_enable), 32'd1);
    chk("issue_a", 32'(mul_a), 32'(ea));
    chk("issue_b", 32'(mul_b), 32'(eb));
    chk("issue_ready", 32'(req_ready), 32'd0);
    tick();
    chk("wait_en", 32'(mul_enable), 32'd0);
    chk("wait_a", 32'(mul_a), 32'(ea));
    chk("wait_b", 32'(mul_b), 32'(eb));
    tick();
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_result", 32'(rsp_result), 32'(eres));
    chk("resp_id", 32'(rsp_id), 32'(g));
    for (int i = 0; i < nstall; i++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", 32'(rsp_result), 32'(eres));
      chk("stall_id", 32'(rsp_id), 32'(g));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    if (nstall > 0) rsp_ready = 1'b1;
    tick();
    chk("post_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_en", 32'(mul_enable), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // No requester: stays idle.
    tick();
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_en", 32'(mul_enable), 32'd0);

    // 3*5, then -3*5, -16*-16, -16*15.
    set_ops(0, 5'd3, 5'd5);
    req_valid = 4'b0001;
    op(0, 5'd3, 5'd5, 10'd15, 0, 4'b0000);
    chk("ops_done_1", 32'(ops_done), 32'd1);
    set_ops(0, 5'h1D, 5'd5);
    req_valid = 4'b0001;
    op(0, 5'h1D, 5'd5, 10'h3F1, 0, 4'b0000);
    set_ops(2, 5'h10, 5'h10);
    req_valid = 4'b0100;
    op(2, 5'h10, 5'h10, 10'h100, 0, 4'b0000);
    set_ops(3, 5'h10, 5'h0F);
    req_valid = 4'b1000;
    op(3, 5'h10, 5'h0F, 10'h310, 0, 4'b0000);
    chk("ops_done_4", 32'(ops_done), 32'd4);

    // Fresh reset, then all four requesting: grants 0,1,2,3,0.
    rst = 1'b0;
    #1;
    chk("rst2_ops_done", 32'(ops_done), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 5'(i + 1), 5'd2);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      op(k % 4, 5'(k % 4 + 1), 5'd2, 10'(2 * (k % 4 + 1)), 0, (k < 4) ? 4'b1111 : 4'b0000);
    end
    chk("ops_done_5", 32'(ops_done), 32'd5);

    // Stall 10 cycles in RESP with req1 waiting; req1 served after release.
    set_ops(0, 5'd7, 5'h1E);
    set_ops(1, 5'h1B, 5'h1B);
    req_valid = 4'b0001;
    op(0, 5'd7, 5'h1E, 10'h3F2, 10, 4'b0010);
    op(1, 5'h1B, 5'h1B, 10'd25, 0, 4'b0000);
    chk("ops_done_7", 32'(ops_done), 32'd7);

    // Async reset while in WAIT; pointer returns to 0 so req1 beats req3.
    set_ops(3, 5'd2, 5'd3);
    req_valid = 4'b1010;
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'b1000);
    tick();
    tick();
    chk("in_wait", 32'(mul_a), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_mul_a", 32'(mul_a), 32'd0);
    chk("arst_mul_b", 32'(mul_b), 32'd0);
    chk("arst_en", 32'(mul_enable), 32'd0);
    chk("arst_result", 32'(rsp_result), 32'd0);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_ops_done", 32'(ops_done), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    op(1, 5'h1B, 5'h1B, 10'd25, 0, 4'b0000);
    chk("ops_done_r1", 32'(ops_done), 32'd1);

    // Counter wrap, with a zero operand against a negative one.
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    set_ops(0, 5'd0, 5'h19);
    req_valid = 4'b0001;
    op(0, 5'd0, 5'h19, 10'd0, 0, 4'b0000);
    chk("ops_done_wrap", 32'(ops_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
